// File: rtl/axis_axi_burst_writer_pkg.sv
// Shared constants and state encoding for the AXI-Stream to AXI4 burst writer.
package axis_axi_burst_writer_pkg;

    localparam logic [1:0]  BURST_INCR           = 2'b01;
    localparam logic [3:0]  CACHE_MODIFIABLE_BUF = 4'b0011;
    localparam logic [1:0]  RESP_OKAY            = 2'b00;
    localparam int unsigned BOUNDARY_4K          = 4096;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

endpackage

// File: rtl/axis_axi_burst_writer_popcount_keep.sv
// Combinational count of asserted byte enables in a tkeep/wstrb vector.
module axis_axi_burst_writer_popcount_keep #(
    parameter int unsigned KEEP_WIDTH = 64
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [31:0]           count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            count = count + 32'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_axi_burst_writer.sv
// Writes one AXI-Stream frame to memory as AXI4 INCR bursts, one burst in
// flight, split at MAX_BURST_LEN and 4 KB pages, tail padded with null strobes.
module axis_axi_burst_writer
    import axis_axi_burst_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH    = 34,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned AXI_ID        = 0
) (
    input  logic                  m_axi_aclk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,

    output logic [5:0]            m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [KEEP_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [5:0]            m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic                  done,
    output logic                  error,
    output logic [31:0]           bytes_written
);

    localparam int unsigned SIZE_LOG2 = $clog2(KEEP_WIDTH);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [8:0]            beat_cnt;
    logic [8:0]            burst_beats;
    logic                  tlast_seen;

    logic [12:0]           bytes_to_4k;
    logic [12:0]           beats_to_4k;
    logic [8:0]            beats;
    logic                  w_fire;
    logic [31:0]           keep_count;
    logic                  unused_bid;

    assign unused_bid = ^m_axi_bid;

    axis_axi_burst_writer_popcount_keep #(
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_popcount_keep (
        .keep  (s_axis_tkeep),
        .count (keep_count)
    );

    // Burst length is derived from cur_addr, which is frozen in AW, so awlen stays stable.
    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, cur_addr[11:0]};
        beats_to_4k = bytes_to_4k >> SIZE_LOG2;
        beats       = (beats_to_4k > 13'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : beats_to_4k[8:0];
    end

    assign m_axi_awid    = 6'(AXI_ID);
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awlen   = 8'(beats - 9'd1);
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_MODIFIABLE_BUF;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wlast   = (state == W) && (beat_cnt == 9'd1);

    always_ff @(posedge m_axi_aclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        s_axis_tready = 1'b0;
        m_axi_bready  = 1'b0;
        w_fire        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = AW;
                end
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_next = W;
                end
            end
            W: begin
                if (tlast_seen) begin
                    m_axi_wvalid = 1'b1;
                end else begin
                    m_axi_wvalid  = s_axis_tvalid;
                    s_axis_tready = m_axi_wready;
                    m_axi_wdata   = s_axis_tdata;
                    m_axi_wstrb   = s_axis_tkeep;
                end
                w_fire = m_axi_wvalid && m_axi_wready;
                if (w_fire && (beat_cnt == 9'd1)) begin
                    state_next = B;
                end
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_next = tlast_seen ? IDLE : AW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk) begin
        if (rst) begin
            cur_addr      <= '0;
            beat_cnt      <= '0;
            burst_beats   <= '0;
            tlast_seen    <= 1'b0;
            bytes_written <= '0;
            error         <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr      <= cmd_addr;
                        bytes_written <= '0;
                        error         <= 1'b0;
                        tlast_seen    <= 1'b0;
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        beat_cnt    <= beats;
                        burst_beats <= beats;
                    end
                end
                W: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt - 9'd1;
                        if (!tlast_seen) begin
                            bytes_written <= bytes_written + keep_count;
                            if (s_axis_tlast) begin
                                tlast_seen <= 1'b1;
                            end
                        end
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != RESP_OKAY) begin
                            error <= 1'b1;
                        end
                        cur_addr <= cur_addr + (ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
                        if (tlast_seen) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_axi_burst_writer.sv
// Scoreboard bench: expected AW/W traffic is generated from the command and
// frame when stimulus is issued, then compared as the DUT emits it.
module tb_axis_axi_burst_writer;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int AW_W = 34;

    logic            m_axi_aclk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [AW_W-1:0] cmd_addr = '0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [5:0]      m_axi_awid;
    logic [AW_W-1:0] m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awlock;
    logic [3:0]      m_axi_awcache;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready = 1'b0;
    logic [DW-1:0]   m_axi_wdata;
    logic [KW-1:0]   m_axi_wstrb;
    logic            m_axi_wlast;
    logic            m_axi_wvalid;
    logic            m_axi_wready = 1'b0;
    logic [5:0]      m_axi_bid = '0;
    logic [1:0]      m_axi_bresp = '0;
    logic            m_axi_bvalid = 1'b0;
    logic            m_axi_bready;
    logic            done;
    logic            error;
    logic [31:0]     bytes_written;

    axis_axi_burst_writer #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .ADDR_WIDTH    (AW_W),
        .MAX_BURST_LEN (16),
        .AXI_ID        (0)
    ) dut (
        .m_axi_aclk    (m_axi_aclk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .done          (done),
        .error         (error),
        .bytes_written (bytes_written)
    );

    always #5 m_axi_aclk = ~m_axi_aclk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic          last;
    } wbeat_t;

    typedef struct {
        logic [AW_W-1:0] addr;
        logic [7:0]      len;
    } aw_t;

    wbeat_t     w_q[$];
    aw_t        aw_q[$];
    logic [1:0] bresp_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  aw_count = 0;
    int  b_pend = 0;
    bit  b_fire = 0;
    bit  rnd_slave = 0;
    int  frame_id = 0;

    bit                   aw_stall_prev = 0;
    logic [AW_W+7:0]      aw_prev = '0;
    bit                   w_stall_prev = 0;
    logic [DW-1:0]        wdata_prev = '0;
    logic [KW:0]          wctl_prev = '0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int f, input int i);
        return {16{f[15:0], i[15:0]}};
    endfunction

    // Reference split of a frame into page-safe bursts with null-strobe tail.
    task automatic build_model(input logic [AW_W-1:0] addr, input int n, input logic [KW-1:0] lastkeep,
                               input logic [1:0] resp0, output int nb, output int nbytes);
        logic [AW_W-1:0] a;
        logic [KW-1:0]   keep;
        int left_idx;
        int room;
        int bl;
        wbeat_t wb;
        a = addr;
        left_idx = 0;
        nb = 0;
        nbytes = 0;
        do begin
            room = (4096 - int'(a[11:0])) / KW;
            bl = (room < 16) ? room : 16;
            aw_q.push_back('{a, 8'(bl - 1)});
            bresp_q.push_back((nb == 0) ? resp0 : 2'b00);
            for (int k = 0; k < bl; k++) begin
                if (left_idx < n) begin
                    keep = (left_idx == n - 1) ? lastkeep : '1;
                    wb.data = beat_data(frame_id, left_idx);
                    wb.strb = keep;
                    nbytes += $countones(keep);
                    left_idx++;
                end else begin
                    wb.data = '0;
                    wb.strb = '0;
                end
                wb.last = (k == bl - 1);
                w_q.push_back(wb);
            end
            a = a + AW_W'(bl * KW);
            nb++;
        end while (left_idx < n);
    endtask

    // Output monitor, sampled on the falling edge.
    initial forever begin
        aw_t e;
        wbeat_t w;
        int end_off;
        @(negedge m_axi_aclk);
        if (rst) begin
            aw_stall_prev = 0;
            w_stall_prev = 0;
        end else begin
            if (aw_stall_prev) begin
                check("aw_hold_valid", m_axi_awvalid, 1);
                check("aw_hold_addr_len", {m_axi_awaddr, m_axi_awlen}, aw_prev);
            end
            if (w_stall_prev) begin
                check("w_hold_valid", m_axi_wvalid, 1);
                check("w_hold_data", m_axi_wdata, wdata_prev);
                check("w_hold_strb_last", {m_axi_wstrb, m_axi_wlast}, wctl_prev);
            end
            aw_stall_prev = m_axi_awvalid && !m_axi_awready;
            aw_prev = {m_axi_awaddr, m_axi_awlen};
            w_stall_prev = m_axi_wvalid && !m_axi_wready;
            wdata_prev = m_axi_wdata;
            wctl_prev = {m_axi_wstrb, m_axi_wlast};

            if (m_axi_awvalid && m_axi_awready) begin
                aw_count++;
                end_off = int'(m_axi_awaddr[11:0]) + (int'(m_axi_awlen) + 1) * KW;
                check("aw_4k_cross", end_off <= 4096, 1);
                check("aw_consts", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                      {6'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000});
                if (aw_q.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    e = aw_q.pop_front();
                    check("awaddr", m_axi_awaddr, e.addr);
                    check("awlen", m_axi_awlen, e.len);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wlast) b_pend++;
                if (w_q.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    w = w_q.pop_front();
                    check("wdata", m_axi_wdata, w.data);
                    check("wstrb", m_axi_wstrb, w.strb);
                    check("wlast", m_axi_wlast, w.last);
                end
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1;
        end
    end

    // Memory-side responder: ready randomisation and B responses after each wlast.
    initial forever begin
        @(posedge m_axi_aclk);
        #1;
        if (rst) begin
            m_axi_bvalid = 0;
            b_pend = 0;
            b_fire = 0;
        end else begin
            if (b_fire) begin
                m_axi_bvalid = 0;
                b_fire = 0;
            end
            if (!m_axi_bvalid && b_pend > 0 && (!rnd_slave || $urandom_range(0, 2) == 0)) begin
                m_axi_bvalid = 1;
                m_axi_bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                b_pend--;
            end
        end
        m_axi_awready = rnd_slave ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axi_wready  = rnd_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic issue_cmd(input logic [AW_W-1:0] addr);
        bit acc;
        int g;
        acc = 0;
        g = 0;
        cmd_addr = addr;
        cmd_valid = 1;
        while (!acc && g < 100) begin
            @(negedge m_axi_aclk);
            acc = cmd_ready;
            @(posedge m_axi_aclk);
            #1;
            g++;
        end
        cmd_valid = 0;
        if (!acc) check("cmd_accept_timeout", 0, 1);
        @(negedge m_axi_aclk);
        check("awvalid_after_cmd", m_axi_awvalid, 1);
        check("error_cleared_on_cmd", error, 0);
        check("bytes_cleared_on_cmd", bytes_written, 0);
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic drive_frame(input int n, input int ndrive, input logic [KW-1:0] lastkeep, input bit gaps);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < ndrive && guard < 4000) begin
            if (!s_axis_tvalid && (!gaps || $urandom_range(0, 2) != 0)) begin
                s_axis_tdata  = beat_data(frame_id, i);
                s_axis_tkeep  = (i == n - 1) ? lastkeep : '1;
                s_axis_tlast  = (i == n - 1);
                s_axis_tvalid = 1;
            end
            @(negedge m_axi_aclk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge m_axi_aclk);
            #1;
            guard++;
            if (acc) begin
                i++;
                s_axis_tvalid = 0;
                s_axis_tlast = 0;
            end
        end
        if (i < ndrive) check("stream_timeout", i, ndrive);
    endtask

    task automatic wait_done(input int exp_bytes, input bit exp_err, input int exp_nb);
        bit seen;
        int g;
        seen = 0;
        g = 0;
        while (!seen && g < 2000) begin
            @(negedge m_axi_aclk);
            seen = done;
            g++;
        end
        check("done_seen", seen, 1);
        check("bytes_written", bytes_written, exp_bytes);
        check("error_at_done", error, exp_err);
        check("cmd_ready_with_done", cmd_ready, 1);
        @(negedge m_axi_aclk);
        check("done_one_cycle", done, 0);
        check("error_sticky", error, exp_err);
        check("aw_handshakes", aw_count, exp_nb);
        check("aw_q_drained", aw_q.size(), 0);
        check("w_q_drained", w_q.size(), 0);
    endtask

    task automatic run_frame(input logic [AW_W-1:0] addr, input int n, input logic [KW-1:0] lastkeep,
                             input bit gaps, input bit rnd, input logic [1:0] resp0);
        int nb;
        int nbytes;
        frame_id++;
        rnd_slave = rnd;
        aw_count = 0;
        build_model(addr, n, lastkeep, resp0, nb, nbytes);
        issue_cmd(addr);
        drive_frame(n, n, lastkeep, gaps);
        wait_done(nbytes, resp0 != 2'b00, nb);
        @(posedge m_axi_aclk);
        #1;
    endtask

    initial begin
        int nb;
        int nbytes;
        repeat (3) @(posedge m_axi_aclk);
        @(negedge m_axi_aclk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready}, 0);
        check("rst_done_error", {done, error}, 0);
        check("rst_bytes", bytes_written, 0);
        @(posedge m_axi_aclk);
        #1;
        rst = 0;
        repeat (2) @(posedge m_axi_aclk);
        #1;

        run_frame(34'h1000, 3, '1, 0, 0, 2'b00);
        run_frame(34'h0, 20, '1, 0, 0, 2'b00);
        run_frame(34'hFC0, 2, '1, 0, 0, 2'b00);
        run_frame(34'h6000, 16, '1, 0, 0, 2'b00);
        run_frame(34'h2000, 40, 64'h00FF, 1, 1, 2'b00);
        run_frame(34'h3000, 20, '1, 0, 1, 2'b10);
        run_frame(34'h4000, 3, '1, 0, 0, 2'b00);

        // Reset mid-burst with a command attempt while busy.
        frame_id++;
        rnd_slave = 0;
        aw_count = 0;
        build_model(34'h0, 20, '1, 2'b00, nb, nbytes);
        issue_cmd(34'h0);
        drive_frame(20, 5, '1, 0);
        cmd_addr = 34'h8000;
        cmd_valid = 1;
        repeat (3) begin
            @(negedge m_axi_aclk);
            check("busy_cmd_ready", cmd_ready, 0);
        end
        @(posedge m_axi_aclk);
        #2;
        cmd_valid = 0;
        rst = 1;
        @(posedge m_axi_aclk);
        @(negedge m_axi_aclk);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready}, 0);
        check("midrst_done_error", {done, error}, 0);
        check("midrst_bytes", bytes_written, 0);
        @(posedge m_axi_aclk);
        #1;
        rst = 0;
        aw_q.delete();
        w_q.delete();
        bresp_q.delete();
        repeat (4) begin
            @(negedge m_axi_aclk);
            check("busy_cmd_dropped", {m_axi_awvalid, cmd_ready}, 2'b01);
        end
        @(posedge m_axi_aclk);
        #1;
        run_frame(34'h5000, 1, 64'h0000_0000_0000_000F, 0, 0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_axi_burst_writer.md
Name: axis_axi_burst_writer

Overview:
- Downstream stage of the capture FIFO: consumes one AXI-Stream frame (FIFO read side) and writes it to memory as AXI4 INCR write bursts starting at a commanded base address.
- Keeps one burst outstanding, splits bursts at MAX_BURST_LEN and at 4 KB boundaries, and pads the final burst with null-strobe beats.
- Reports completion, byte count and write-response errors to the capture control logic.

Parameters:
- DATA_WIDTH, 512: AXIS/AXI data width, bits.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep/wstrb width.
- ADDR_WIDTH, 34: AXI address width.
- MAX_BURST_LEN, 16: maximum beats per burst; range 1..256.
- AXI_ID, 0: constant value driven on m_axi_awid.

Ports:
- m_axi_aclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  start request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_WIDTH  base address; must be KEEP_WIDTH-aligned.
- s_axis_tdata  in  DATA_WIDTH  frame data.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tlast  in  1  end of frame.
- s_axis_tvalid  in  1  data valid.
- s_axis_tready  out  1  data ready.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  6/ADDR_WIDTH/8/3/2/1/4/3/1  AW channel.
- m_axi_awready  in  1  AW ready.
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/KEEP_WIDTH/1/1  W channel.
- m_axi_wready  in  1  W ready.
- m_axi_bid  in  6  write response ID; ignored.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.
- done  out  1  one-cycle pulse when the frame is fully acknowledged.
- error  out  1  sticky; cleared on the next accepted command.
- bytes_written  out  32  popcount of tkeep over accepted beats of the current frame.

Behaviour:
- Reset: state IDLE. cmd_ready=1. All valids, s_axis_tready, m_axi_bready, done, error and bytes_written are 0. Address and counters are 0.
- Constants: awsize=log2(KEEP_WIDTH), awburst=2'b01, awlock=0, awcache=4'b0011, awprot=3'b000, awid=AXI_ID.
- IDLE:
  - On cmd_valid&cmd_ready: latch cur_addr=cmd_addr, clear bytes_written and error, go to AW.
  - No stream beats are accepted in IDLE.
- AW:
  - beats = min(MAX_BURST_LEN, (4096 - cur_addr[11:0]) / KEEP_WIDTH).
  - Drive awaddr=cur_addr, awlen=beats-1, awvalid=1. Hold all AW signals stable until awready.
  - On handshake: load beat_cnt=beats, go to W.
- W:
  - Normal mode: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready, wdata=tdata, wstrb=tkeep.
  - Pad mode (entered after the frame's tlast beat if burst beats remain): wvalid=1, wdata=0, wstrb=0, s_axis_tready=0.
  - wlast=1 exactly when beat_cnt==1.
  - Each W handshake decrements beat_cnt. In normal mode it also adds popcount(tkeep) to bytes_written.
  - On the last beat: go to B.
- B:
  - bready=1.
  - On bvalid: if bresp!=2'b00, set error.
  - Then cur_addr += beats*KEEP_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - If the frame's tlast has been seen: pulse done for one cycle and go to IDLE. Otherwise go to AW.
- Latency: awvalid rises the cycle after the command is accepted. After the last B handshake, done pulses on the next cycle and cmd_ready is high on that same cycle.
- tlast on the final beat of a burst: no pad beats; frame completes after B.
- tlast together with wlast in the first burst: single burst, then done.
- An error does not abort the frame.
- A cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-burst returns to reset values immediately. The downstream interconnect is reset with the same rst.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR, CACHE_MODIFIABLE_BUF, RESP_OKAY.
  - 4 KB boundary constant.
  - State enum: IDLE, AW, W, B.
- Natural sub-module: popcount_keep, a combinational tkeep popcount, also reusable by the capture stage.

Test Plan:
- DATA_WIDTH=512, MAX_BURST_LEN=16, cmd_addr=0x1000, 3-beat frame with full tkeep -> single AW (awaddr 0x1000, awlen 15); 3 data beats then 13 beats with wstrb=0; wlast on beat 16; bresp OKAY -> done pulse, bytes_written=192, error=0.
- 20-beat frame at 0x0 -> AW 0x0/len15, then AW 0x400/len15 (4 data + 12 pad beats); bytes_written=1280.
- cmd_addr=0xFC0, 2-beat frame -> AW 0xFC0/len0, then AW 0x1000/len15 with 1 data + 15 pad beats; no burst crosses a 4 KB boundary.
- Random wready/tvalid/awready/bvalid gaps on a 40-beat frame -> output wdata order equals input order; AW/W held stable under stall; exactly 3 AW handshakes.
- SLVERR on the first of two bursts -> error=1 sticky; second burst still issued; done pulses; next cmd acceptance clears error.
- rst asserted in W state mid-burst; cmd_valid pulsed while busy -> all outputs at reset values the cycle after rst; the busy-time command is not accepted.
